// File: rtl/switch_button_reader.sv
// -----------------------------------------------------------------------------
// switch_button_reader
//
// Memory-mapped input peripheral on the CPU data bus. It sits beside data
// memory in the MEM stage. The bus mux selects Read_data whenever Hit=1.
//
// Each raw board input (slide switches and push-buttons) is handled as follows:
//   1. It passes through a 2-flop synchroniser.
//   2. It is debounced with a per-bit stability counter.
//   3. It is published to software through loads.
//
// A button that is accepted as pressed (0->1) sets a sticky flag in PEND.
// Software clears PEND bits with write-1-to-clear stores.
//
// Register map (word addresses; anything else gives Hit=0, Read_data=0):
//   0x40000014  DATA  RO   [SW_W-1:0]      debounced switches
//                          [8+BTN_W-1:8]   debounced buttons
//   0x40000018  PEND  W1C  [BTN_W-1:0]     sticky press flags
//   0x4000001C  IEN   RW   [BTN_W-1:0]     interrupt enables (BTN_IRQ_EN only)
//
// Optional feature macro: BTN_IRQ_EN
//   - When defined, the IEN register is present.
//   - irq is then a registered |(PEND & IEN).
//   - When undefined, 0x4000001C is unmapped and irq is tied to 0.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   Address     byte address from the MEM stage
//   Write_data  store data
//   MemRead     load strobe
//   MemWrite    store strobe
//   sw_raw      raw switch pins (asynchronous)
//   btn_raw     raw button pins (asynchronous, 1 = pressed)
//   Read_data   load data (combinational from registers, 0 when not hit)
//   Hit         Address is mapped here and MemRead=1
//   irq         button interrupt request (0 unless BTN_IRQ_EN)
// -----------------------------------------------------------------------------
module switch_button_reader #(
    parameter int SW_W         = 8,
    parameter int BTN_W        = 4,
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_MAX = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Address,
    input  logic [31:0]      Write_data,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [BTN_W-1:0] btn_raw,
    output logic [31:0]      Read_data,
    output logic             Hit,
    output logic             irq
);

    localparam int NB = SW_W + BTN_W;

    // The counter accepts the new level on the cycle it would reach DEBOUNCE_MAX.
    // Because of this, the counter never needs to wrap or saturate.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

    // Word addresses (byte address >> 2).
    localparam logic [29:0] WADDR_DATA = 30'h1000_0005;
    localparam logic [29:0] WADDR_PEND = 30'h1000_0006;
    localparam logic [29:0] WADDR_IEN  = 30'h1000_0007;

    // All raw inputs handled uniformly.
    // Switches occupy the low bits and buttons occupy the high bits.
    logic [NB-1:0] raw_all;
    logic [NB-1:0] deb_vec;
    logic [NB-1:0] rise_vec;

    assign raw_all = {btn_raw, sw_raw};

    // -------------------------------------------------------------------------
    // Per-bit synchroniser and debouncer
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bit
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             accept;

            always_comb begin
                cnt_next = cnt_reg;
                deb_next = deb_reg;
                accept   = 1'b0;
                if (sync2_reg == deb_reg) begin
                    // Stable, or a glitch back to the accepted level: restart the count.
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    deb_next = sync2_reg;
                    cnt_next = '0;
                    accept   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_all[gi];
                    sync2_reg <= sync1_reg;
                    deb_reg   <= deb_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign deb_vec[gi] = deb_reg;

            // This pulse is high in the cycle before deb_reg goes 0->1.
            // PEND therefore sets on the same edge that the level is accepted.
            assign rise_vec[gi] = accept & sync2_reg;
        end
    endgenerate

    logic [SW_W-1:0]  sw_deb;
    logic [BTN_W-1:0] btn_deb;
    logic [BTN_W-1:0] pend_set;

    assign sw_deb   = deb_vec[SW_W-1:0];
    assign btn_deb  = deb_vec[NB-1:SW_W];
    assign pend_set = rise_vec[NB-1:SW_W];

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [29:0] word_addr;
    logic        sel_data;
    logic        sel_pend;
    logic        sel_ien;

    assign word_addr = Address[31:2];
    assign sel_data  = (word_addr == WADDR_DATA);
    assign sel_pend  = (word_addr == WADDR_PEND);

`ifdef BTN_IRQ_EN
    assign sel_ien = (word_addr == WADDR_IEN);
`else
    assign sel_ien = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // PEND: sticky press flags, write-1-to-clear.
    // A set and a clear of the same bit in one cycle leave the bit set.
    // -------------------------------------------------------------------------
    logic [BTN_W-1:0] pend_reg;
    logic [BTN_W-1:0] pend_next;
    logic [BTN_W-1:0] pend_clr;

    assign pend_clr  = (MemWrite && sel_pend) ? Write_data[BTN_W-1:0] : '0;
    assign pend_next = (pend_reg & ~pend_clr) | pend_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // -------------------------------------------------------------------------
    // Optional interrupt enable and registered interrupt
    // -------------------------------------------------------------------------
    logic [BTN_W-1:0] ien_val;

`ifdef BTN_IRQ_EN
    logic [BTN_W-1:0] ien_reg;
    logic             irq_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ien_reg <= '0;
            irq_reg <= 1'b0;
        end else begin
            if (MemWrite && sel_ien) begin
                ien_reg <= Write_data[BTN_W-1:0];
            end
            // Built from current register values, so irq trails PEND/IEN by one cycle.
            irq_reg <= |(pend_reg & ien_reg);
        end
    end

    assign ien_val = ien_reg;
    assign irq     = irq_reg;
`else
    assign ien_val = '0;
    assign irq     = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read path. Loads have no side effects.
    // Hit is held low while reset is asserted.
    // -------------------------------------------------------------------------
    assign Hit = reset & MemRead & (sel_data | sel_pend | sel_ien);

    always_comb begin
        Read_data = '0;
        if (Hit) begin
            if (sel_data) begin
                Read_data[SW_W-1:0]    = sw_deb;
                Read_data[8+BTN_W-1:8] = btn_deb;
            end else if (sel_pend) begin
                // Shows the pre-clear value when a W1C store lands in the same cycle.
                Read_data[BTN_W-1:0] = pend_reg;
            end else begin
                Read_data[BTN_W-1:0] = ien_val;
            end
        end
    end

    // These bits are intentionally ignored:
    //   - byte offset within the word
    //   - store data above the button field
    //   - switch accept pulses
    logic unused_bits;
    assign unused_bits = &{1'b0, Address[1:0], Write_data[31:BTN_W], rise_vec[SW_W-1:0]};

endmodule

// File: tb/tb_switch_button_reader.sv
module tb_switch_button_reader;

    localparam logic [31:0] A_LED  = 32'h4000_0010;
    localparam logic [31:0] A_DATA = 32'h4000_0014;
    localparam logic [31:0] A_PEND = 32'h4000_0018;
    localparam logic [31:0] A_IEN  = 32'h4000_001C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  sw_raw;
    logic [3:0]  btn_raw;
    logic [31:0] Read_data;
    logic        Hit;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd_val;
    logic        rd_hit;

    switch_button_reader #(
        .SW_W(8),
        .BTN_W(4),
        .CNT_W(16),
        .DEBOUNCE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .Write_data(Write_data),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .Read_data(Read_data),
        .Hit(Hit),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Advance n cycles; return 1 time unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Combinational load: present address and strobe, sample, then drop the strobe.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic hit);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data    = Read_data;
        hit     = Hit;
        MemRead = 1'b0;
        $display("load  addr=0x%08h data=0x%08h hit=%0b", addr, data, hit);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        tick(1);
        MemWrite   = 1'b0;
        $display("store addr=0x%08h data=0x%08h", addr, data);
    endtask

    initial begin
        reset      = 1'b0;
        Address    = '0;
        Write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        sw_raw     = '0;
        btn_raw    = '0;
        tick(2);

        // ---------------------------------------------------------------
        // Reset state: outputs are 0 even with a load presented.
        // ---------------------------------------------------------------
        Address = A_DATA;
        MemRead = 1'b1;
        #1;
        check("rst_rdata", Read_data, 32'h0);
        check("rst_hit", {31'b0, Hit}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        MemRead = 1'b0;
        reset   = 1'b1;
        tick(1);

        // ---------------------------------------------------------------
        // Test 1: reset mid-debounce discards the partial count.
        // ---------------------------------------------------------------
        sw_raw = 8'hFF;
        tick(4);
        reset  = 1'b0;
        sw_raw = 8'h00;
        Address = A_DATA;
        MemRead = 1'b1;
        #1;
        check("t1_rst_rdata", Read_data, 32'h0);
        check("t1_rst_hit", {31'b0, Hit}, 32'h0);
        check("t1_rst_irq", {31'b0, irq}, 32'h0);
        MemRead = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        bus_read(A_DATA, rd_val, rd_hit);
        check("t1_data", rd_val, 32'h0);
        check("t1_hit", {31'b0, rd_hit}, 32'h1);
        tick(8);
        bus_read(A_DATA, rd_val, rd_hit);
        check("t1_data_late", rd_val, 32'h0);

        // ---------------------------------------------------------------
        // Test 2: the accepted level appears exactly 2+4 cycles after the pin.
        // ---------------------------------------------------------------
        sw_raw = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            bus_read(A_DATA, rd_val, rd_hit);
            check($sformatf("t2_data_cyc%0d", k), rd_val, (k < 6) ? 32'h0 : 32'hA5);
        end

        // ---------------------------------------------------------------
        // Test 3: bit 0 toggles every 3 cycles, so each excursion is too
        // short to be accepted.
        // ---------------------------------------------------------------
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) sw_raw[0] = ~sw_raw[0];
            tick(1);
            bus_read(A_DATA, rd_val, rd_hit);
            check($sformatf("t3_glitch_%0d", k), rd_val, 32'hA5);
        end
        tick(4);
        bus_read(A_DATA, rd_val, rd_hit);
        check("t3_after", rd_val, 32'hA5);

        // ---------------------------------------------------------------
        // Bus boundaries: unmapped address, no strobe, store to DATA.
        // ---------------------------------------------------------------
        bus_read(A_LED, rd_val, rd_hit);
        check("unmapped_data", rd_val, 32'h0);
        check("unmapped_hit", {31'b0, rd_hit}, 32'h0);
        Address = A_DATA;
        MemRead = 1'b0;
        #1;
        check("noread_rdata", Read_data, 32'h0);
        check("noread_hit", {31'b0, Hit}, 32'h0);
        bus_write(A_DATA, 32'hFFFF_FFFF);
        bus_read(A_DATA, rd_val, rd_hit);
        check("store_data_ignored", rd_val, 32'hA5);

        // ---------------------------------------------------------------
        // Test 4: press, hold, release btn[2], then W1C.
        // ---------------------------------------------------------------
        btn_raw = 4'b0100;
        tick(5);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t4_pend_early", rd_val, 32'h0);
        tick(1);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t4_pend_press", rd_val, 32'h4);
        bus_read(A_DATA, rd_val, rd_hit);
        check("t4_data_press", rd_val, 32'h4A5);
        btn_raw = 4'b0000;
        tick(8);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t4_pend_release", rd_val, 32'h4);
        bus_read(A_DATA, rd_val, rd_hit);
        check("t4_data_release", rd_val, 32'hA5);

        // Same-cycle load and W1C store return the pre-clear value.
        Address    = A_PEND;
        Write_data = 32'h4;
        MemWrite   = 1'b1;
        MemRead    = 1'b1;
        #1;
        check("t4_rd_preclear", Read_data, 32'h4);
        tick(1);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        $display("store addr=0x%08h data=0x%08h (with load)", A_PEND, 32'h4);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t4_pend_cleared", rd_val, 32'h0);

        // ---------------------------------------------------------------
        // Test 5: a W1C of 0xF on the btn[1] press edge leaves bit 1 set.
        // ---------------------------------------------------------------
        btn_raw = 4'b0001;
        tick(6);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t5_pend_b0", rd_val, 32'h1);
        btn_raw = 4'b0011;
        tick(5);
        Address    = A_PEND;
        Write_data = 32'hF;
        MemWrite   = 1'b1;
        tick(1);
        MemWrite = 1'b0;
        $display("store addr=0x%08h data=0x%08h (on press edge)", A_PEND, 32'hF);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t5_pend_setwins", rd_val, 32'h2);
        bus_read(A_DATA, rd_val, rd_hit);
        check("t5_data", rd_val, 32'h3A5);

        // Return to a quiet state: buttons released, PEND empty.
        btn_raw = 4'b0000;
        tick(8);
        bus_write(A_PEND, 32'hF);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t6_pend_empty", rd_val, 32'h0);

        // ---------------------------------------------------------------
        // Test 6: interrupt path.
        // ---------------------------------------------------------------
`ifdef BTN_IRQ_EN
        bus_write(A_IEN, 32'h1);
        bus_read(A_IEN, rd_val, rd_hit);
        check("t6_ien", rd_val, 32'h1);
        btn_raw = 4'b0001;
        tick(6);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t6_pend", rd_val, 32'h1);
        check("t6_irq_lag", {31'b0, irq}, 32'h0);
        tick(1);
        check("t6_irq_set", {31'b0, irq}, 32'h1);
        bus_write(A_PEND, 32'h1);
        check("t6_irq_hold", {31'b0, irq}, 32'h1);
        tick(1);
        check("t6_irq_clr", {31'b0, irq}, 32'h0);
`else
        btn_raw = 4'b0001;
        tick(6);
        bus_read(A_PEND, rd_val, rd_hit);
        check("t6_pend", rd_val, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check($sformatf("t6_irq_off_%0d", k), {31'b0, irq}, 32'h0);
        end
        bus_read(A_IEN, rd_val, rd_hit);
        check("t6_ien_hit", {31'b0, rd_hit}, 32'h0);
        check("t6_ien_data", rd_val, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
